// File: rtl/sprite_stream_rom.sv
// sprite_stream_rom: loadable sprite RAM that streams one sprite per request,
// row-major, over a valid/ready handshake with local coordinates and opacity.
// Optional build macro SPRITE_FLIP_EN adds per-request horizontal/vertical mirroring.
// req_sprite carries one extra code point so that out-of-range requests can be flagged.
module sprite_stream_rom #(
    parameter int unsigned NUM_SPRITES     = 2,
    parameter int unsigned SPRITE_W        = 18,
    parameter int unsigned SPRITE_H        = 25,
    parameter int unsigned IDX_W           = 6,
    parameter int unsigned TRANSPARENT_IDX = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0]     wr_sprite,
    input  logic [$clog2(SPRITE_H)-1:0]        wr_row,
    input  logic [$clog2(SPRITE_W)-1:0]        wr_col,
    input  logic [IDX_W-1:0]                   wr_data,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [$clog2(NUM_SPRITES+1)-1:0]   req_sprite,
`ifdef SPRITE_FLIP_EN
    input  logic                               req_flip_h,
    input  logic                               req_flip_v,
`endif
    output logic                               req_err,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [IDX_W-1:0]                   out_pixel,
    output logic                               out_opaque,
    output logic [$clog2(SPRITE_W)-1:0]        out_x,
    output logic [$clog2(SPRITE_H)-1:0]        out_y,
    output logic                               out_last,
    output logic                               busy
);

    localparam int unsigned SPR_W  = $clog2(NUM_SPRITES);
    localparam int unsigned COL_W  = $clog2(SPRITE_W);
    localparam int unsigned ROW_W  = $clog2(SPRITE_H);
    localparam int unsigned DEPTH  = NUM_SPRITES * SPRITE_W * SPRITE_H;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);
    localparam logic [IDX_W-1:0] TRANSP   = IDX_W'(TRANSPARENT_IDX);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  mem [DEPTH];
    logic [SPR_W-1:0]  spr;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              flip_h;
    logic              flip_v;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [IDX_W-1:0]  rd_data;
    logic              wr_ok;
    logic              req_legal;
    logic              at_last;
    logic              start_c;
    logic              err_c;
    logic              adv_c;
    logic              drain_c;

    // Address generation, mirroring and range qualification
    always_comb begin
        rd_row    = flip_v ? (ROW_LAST - row) : row;
        rd_col    = flip_h ? (COL_LAST - col) : col;
        rd_addr   = ADDR_W'((32'(spr) * SPRITE_H + 32'(rd_row)) * SPRITE_W + 32'(rd_col));
        wr_addr   = ADDR_W'((32'(wr_sprite) * SPRITE_H + 32'(wr_row)) * SPRITE_W + 32'(wr_col));
        wr_ok     = wr_en && (32'(wr_sprite) < NUM_SPRITES)
                          && (32'(wr_row) < SPRITE_H) && (32'(wr_col) < SPRITE_W);
        req_legal = (32'(req_sprite) < NUM_SPRITES);
        at_last   = (row == ROW_LAST) && (col == COL_LAST);
    end

    assign rd_data = mem[rd_addr];

    // Sprite RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_c)           next_state = STREAM;
            STREAM:  if (adv_c && at_last)  next_state = DRAIN;
            DRAIN:   if (drain_c)           next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    // FSM control outputs steering the datapath
    always_comb begin
        start_c = 1'b0;
        err_c   = 1'b0;
        adv_c   = 1'b0;
        drain_c = 1'b0;
        case (state)
            IDLE: begin
                start_c = req_valid && req_legal;
                err_c   = req_valid && !req_legal;
            end
            STREAM:  adv_c   = !out_valid || out_ready;
            DRAIN:   drain_c = out_ready;
            default: ;
        endcase
    end

    // Counters, registered RAM read and output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spr        <= '0;
            row        <= '0;
            col        <= '0;
            req_ready  <= 1'b1;
            req_err    <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            out_opaque <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
        end else begin
            req_err   <= err_c;
            req_ready <= (next_state == IDLE);
            busy      <= (next_state != IDLE);
            if (start_c) begin
                spr <= req_sprite[SPR_W-1:0];
                row <= '0;
                col <= '0;
            end
            if (adv_c) begin
                out_pixel  <= rd_data;
                out_opaque <= (rd_data != TRANSP);
                out_x      <= col;
                out_y      <= row;
                out_valid  <= 1'b1;
                out_last   <= at_last;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= at_last ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (drain_c) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef SPRITE_FLIP_EN
    // Mirror controls captured with the request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flip_h <= 1'b0;
            flip_v <= 1'b0;
        end else if (start_c) begin
            flip_h <= req_flip_h;
            flip_v <= req_flip_v;
        end
    end
`else
    assign flip_h = 1'b0;
    assign flip_v = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_stream_rom.sv
// tb_sprite_stream_rom: randomized self-checking bench for sprite_stream_rom.
// A bitmap array model of the sprite store predicts every streamed beat.
module tb_sprite_stream_rom;

    localparam int NS = 2;
    localparam int W  = 18;
    localparam int H  = 25;
    localparam int NB = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [0:0] wr_sprite;
    logic [4:0] wr_row;
    logic [4:0] wr_col;
    logic [5:0] wr_data;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sprite;
    logic       req_err;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_pixel;
    logic       out_opaque;
    logic [4:0] out_x;
    logic [4:0] out_y;
    logic       out_last;
    logic       busy;
`ifdef SPRITE_FLIP_EN
    logic       req_flip_h;
    logic       req_flip_v;
`endif

    logic [5:0] model [NS][H][W];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_stream_rom dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_sprite  (wr_sprite),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sprite (req_sprite),
`ifdef SPRITE_FLIP_EN
        .req_flip_h (req_flip_h),
        .req_flip_v (req_flip_v),
`endif
        .req_err    (req_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_opaque (out_opaque),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .busy       (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One write per cycle; out-of-range coordinates leave the model untouched
    task automatic write_px(input int s, input int r, input int c, input int d);
        wr_en     = 1'b1;
        wr_sprite = 1'(s);
        wr_row    = 5'(r);
        wr_col    = 5'(c);
        wr_data   = 6'(d);
        if (r < H && c < W) model[s][r][c] = 6'(d);
        tick();
        wr_en = 1'b0;
    endtask

    // Request sprite s and consume all beats; mode 0: ready=1, 1: 1,0,0,1 pattern, 2: random
    task automatic stream(input int s, input bit fh, input bit fv, input int mode, input bit side_wr);
        int k;
        int cyc;
        int first_v;
        int ph;
        int ex;
        int ey;
        int rx;
        int ry;
        bit held;
        logic [5:0]  ep;
        logic [18:0] snap;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_start_ready: got %b want 1", req_ready);
        end
        req_sprite = 2'(s);
        req_valid  = 1'b1;
`ifdef SPRITE_FLIP_EN
        req_flip_h = fh;
        req_flip_v = fv;
`endif
        out_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        k = 0; cyc = 0; first_v = -1; ph = 0; held = 1'b0; snap = '0;
        while (k < NB && cyc < 20 * NB) begin
            if (held) begin
                checks++;
                if ({out_valid, out_pixel, out_opaque, out_x, out_y, out_last} !== snap) begin
                    errors++;
                    $display("FAIL hold_stable beat %0d: got %h want %h", k,
                             {out_valid, out_pixel, out_opaque, out_x, out_y, out_last}, snap);
                end
            end
            if (out_valid && first_v < 0) first_v = cyc;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            if (side_wr) begin
                wr_en     = 1'($urandom_range(0, 1));
                wr_sprite = 1'b1;
                wr_row    = 5'($urandom_range(0, H - 1));
                wr_col    = 5'($urandom_range(0, W - 1));
                wr_data   = 6'($urandom);
                if (wr_en) model[1][wr_row][wr_col] = wr_data;
            end
            if (out_valid && out_ready) begin
                ey = k / W;
                ex = k % W;
                ry = fv ? (H - 1 - ey) : ey;
                rx = fh ? (W - 1 - ex) : ex;
                ep = model[s][ry][rx];
                checks++;
                if ({out_pixel, out_opaque, out_x, out_y, out_last} !==
                    {ep, (ep != 6'd0), 5'(ex), 5'(ey), (k == NB - 1)}) begin
                    errors++;
                    $display("FAIL beat %0d: got px=%0d op=%b x=%0d y=%0d last=%b, want px=%0d op=%b x=%0d y=%0d last=%b",
                             k, out_pixel, out_opaque, out_x, out_y, out_last,
                             ep, (ep != 6'd0), ex, ey, (k == NB - 1));
                end
                k++;
            end
            held = out_valid && !out_ready;
            snap = {out_valid, out_pixel, out_opaque, out_x, out_y, out_last};
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        checks++;
        if (k != NB) begin
            errors++;
            $display("FAIL stream_timeout: got %0d beats want %0d", k, NB);
        end
        checks++;
        if (first_v != 1) begin
            errors++;
            $display("FAIL first_latency: got %0d want 1 cycle after FSM entry", first_v);
        end
        checks++;
        if ({out_valid, req_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL stream_end: got valid/ready/busy=%b want 010", {out_valid, req_ready, busy});
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        checks++;
        if ({req_err, out_valid, out_opaque, out_last, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {req_err, out_valid, out_opaque, out_last, busy});
        end
        checks++;
        if ({out_pixel, out_x, out_y} !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {out_pixel, out_x, out_y});
        end
        reset = 1'b0;
        tick();
    endtask

    // Ramp sprite 0, plus out-of-range writes that must not alias into it
    task automatic test_load_stream;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                write_px(0, r, c, (r * W + c) % 64);
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) write_px(int'($urandom_range(0, 1)), int'($urandom_range(H, 31)),
                                     int'($urandom_range(0, 31)), int'($urandom_range(1, 63)));
            else            write_px(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                                     int'($urandom_range(W, 31)), int'($urandom_range(1, 63)));
        end
        stream(0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Tank-like sprite 1 with a transparent first row and sparse transparency
    task automatic test_tank;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                write_px(1, r, c, (r == 0) ? 0 :
                         ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 63)));
        write_px(1, 1, 7, 4);
        stream(1, 1'b0, 1'b0, 2, 1'b0);
    endtask

    // Patterned backpressure with concurrent writes, then back-to-back request
    task automatic test_back_to_back;
        stream(0, 1'b0, 1'b0, 1, 1'b1);
        stream(1, 1'b0, 1'b0, 2, 1'b0);
    endtask

    task automatic test_bad_request;
        for (int s = NS; s < 4; s++) begin
            int pulses;
            pulses = 0;
            req_sprite = 2'(s);
            req_valid  = 1'b1;
            tick();
            req_valid = 1'b0;
            checks++;
            if (req_err !== 1'b1) begin
                errors++;
                $display("FAIL bad_req_err sprite %0d: got %b want 1", s, req_err);
            end
            for (int i = 0; i < 4; i++) begin
                if (req_err === 1'b1) pulses++;
                checks++;
                if ({out_valid, busy, req_ready} !== 3'b001) begin
                    errors++;
                    $display("FAIL bad_req_idle sprite %0d: got valid/busy/ready=%b want 001",
                             s, {out_valid, busy, req_ready});
                end
                tick();
            end
            checks++;
            if (pulses != 1) begin
                errors++;
                $display("FAIL bad_req_pulses sprite %0d: got %0d want 1", s, pulses);
            end
        end
    endtask

    // Abandon a stream at beat 100, then verify the RAM survived reset
    task automatic test_reset_mid;
        int k;
        int cyc;
        req_sprite = 2'd0;
        req_valid  = 1'b1;
        out_ready  = 1'b1;
        tick();
        req_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 100 && cyc < 1000) begin
            if (out_valid) k++;
            tick();
            cyc++;
        end
        checks++;
        if (k != 100) begin
            errors++;
            $display("FAIL mid_reach_100: got %0d want 100", k);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, req_ready, busy, out_last} !== 4'b0100) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want 0100", {out_valid, req_ready, busy, out_last});
        end
        tick();
        checks++;
        if ({out_valid, req_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL mid_reset_edge: got %b want 010", {out_valid, req_ready, busy});
        end
        reset = 1'b0;
        tick();
        stream(0, 1'b0, 1'b0, 0, 1'b0);
    endtask

`ifdef SPRITE_FLIP_EN
    task automatic test_flip;
        stream(0, 1'b1, 1'b0, 0, 1'b0);
        stream(0, 1'b1, 1'b1, 2, 1'b0);
        stream(1, 1'b0, 1'b1, 1, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sprite = '0; wr_row = '0; wr_col = '0; wr_data = '0;
        req_valid = 1'b0; req_sprite = '0; out_ready = 1'b0;
`ifdef SPRITE_FLIP_EN
        req_flip_h = 1'b0;
        req_flip_v = 1'b0;
`endif
        test_reset();
        test_load_stream();
        test_tank();
        test_back_to_back();
        test_bad_request();
        test_reset_mid();
`ifdef SPRITE_FLIP_EN
        test_flip();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
